// File: rtl/asip_stats_sequencer.sv
// Sequencer for the ASIP max/min/average datapath: streams a block of samples,
// then divides the running sum by the sample count with a restoring divider.
module asip_stats_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SUM_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [7:0]        COUNT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RD,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] MAX,
  output logic [DATA_W-1:0] MIN,
  output logic [DATA_W-1:0] QUOTIENT,
  output logic [DATA_W-1:0] REMAINDER
);

  // state | meaning
  // IDLE  | waiting for START
  // FETCH | one read per cycle, idx = 0..COUNT-1
  // DRAIN | accumulate the last returning sample
  // DIV   | SUM_W restoring-divide iterations, MSB first
  // FIN   | DONE pulse, results already loaded
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_DIV, S_FIN} state_t;

  localparam int DC_W = $clog2(SUM_W);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [7:0]        cnt;
  logic [7:0]        idx;
  logic              vld;
  logic [DATA_W-1:0] work_max, work_min;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DC_W-1:0]   div_cnt;

  logic [DATA_W:0]   rem_sh, rem_sub;
  logic              q_bit;
  logic [DATA_W-1:0] rem_next;

  // rem < cnt always holds, so the borrow of the trial subtraction is the
  // inverted quotient bit.
  always_comb begin
    rem_sh   = {rem, sum[div_cnt]};
    rem_sub  = rem_sh - {1'b0, DATA_W'(cnt)};
    q_bit    = ~rem_sub[DATA_W];
    rem_next = q_bit ? rem_sub[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (START) state_next = (COUNT == 8'd0) ? S_FIN : S_FETCH;
      S_FETCH: if (idx == cnt - 8'd1) state_next = S_DRAIN;
      S_DRAIN: state_next = S_DIV;
      S_DIV:   if (div_cnt == '0) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = (state != S_IDLE);
    DONE     = (state == S_FIN);
    MEM_RD   = (state == S_FETCH);
    MEM_ADDR = MEM_RD ? base + ADDR_W'(idx) : '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      base      <= '0;
      cnt       <= '0;
      idx       <= '0;
      vld       <= 1'b0;
      work_max  <= '0;
      work_min  <= '0;
      sum       <= '0;
      rem       <= '0;
      quo       <= '0;
      div_cnt   <= '0;
      MAX       <= '0;
      MIN       <= '0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
      ERR       <= 1'b0;
    end else begin
      vld <= (state == S_FETCH);
      if (vld) begin
        if (MEM_RDATA > work_max) work_max <= MEM_RDATA;
        if (MEM_RDATA < work_min) work_min <= MEM_RDATA;
        sum <= sum + SUM_W'(MEM_RDATA);
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            if (COUNT != 8'd0) begin
              base     <= BASE_ADDR;
              cnt      <= COUNT;
              idx      <= '0;
              work_max <= '0;
              work_min <= '1;
              sum      <= '0;
            end else begin
              MAX       <= '0;
              MIN       <= '0;
              QUOTIENT  <= '0;
              REMAINDER <= '0;
              ERR       <= 1'b1;
            end
          end
        end
        S_FETCH: idx <= idx + 8'd1;
        S_DRAIN: begin
          rem     <= '0;
          quo     <= '0;
          div_cnt <= DC_W'(SUM_W - 1);
        end
        S_DIV: begin
          rem     <= rem_next;
          quo     <= {quo[DATA_W-2:0], q_bit};
          div_cnt <= div_cnt - 1'b1;
          if (div_cnt == '0) begin
            MAX       <= work_max;
            MIN       <= work_min;
            QUOTIENT  <= {quo[DATA_W-2:0], q_bit};
            REMAINDER <= rem_next;
            ERR       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asip_stats_sequencer.sv
// Scoreboard bench for asip_stats_sequencer: a stimulus thread predicts each
// run from a plain-arithmetic model, a monitor checks reads and DONE results.
module tb_asip_stats_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] BASE_ADDR = '0;
  logic [7:0] COUNT = '0;
  logic [7:0] MEM_ADDR;
  logic       MEM_RD;
  logic [7:0] MEM_RDATA = '0;
  logic       BUSY, DONE, ERR;
  logic [7:0] MAX, MIN, QUOTIENT, REMAINDER;

  asip_stats_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR), .COUNT(COUNT),
    .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD), .MEM_RDATA(MEM_RDATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .MAX(MAX), .MIN(MIN), .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [256];
  always @(posedge CLK) if (MEM_RD) MEM_RDATA <= mem[MEM_ADDR];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int mx; int mn; int q; int r; int err; int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      if (MEM_RD) begin
        if (addr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got addr %0d expected no read", MEM_ADDR);
        end else chk("mem_addr", int'(MEM_ADDR), addr_q.pop_front());
      end
      if (DONE) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got DONE=1 expected no DONE");
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("max", int'(MAX), mon_e.mx);
          chk("min", int'(MIN), mon_e.mn);
          chk("quotient", int'(QUOTIENT), mon_e.q);
          chk("remainder", int'(REMAINDER), mon_e.r);
          chk("err", int'(ERR), mon_e.err);
          chk("busy_in_done", int'(BUSY), 1);
        end
      end
    end
  end

  // Model: statistics over the sampled block with wrap-around addressing.
  task automatic kick(input int base, input int count, input bit pulse2, output int c0);
    exp_t e;
    int   mx = 0, mn = 255, s = 0, a, v;
    for (int i = 0; i < count; i++) begin
      a = (base + i) % 256;
      v = int'(mem[a]);
      addr_q.push_back(a);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
      s += v;
    end
    if (count == 0) begin
      e.mx = 0; e.mn = 0; e.q = 0; e.r = 0; e.err = 1;
    end else begin
      e.mx = mx; e.mn = mn; e.q = s / count; e.r = s % count; e.err = 0;
    end
    @(negedge CLK);
    BASE_ADDR = 8'(base);
    COUNT     = 8'(count);
    START     = 1'b1;
    @(posedge CLK);
    #1;
    c0 = cyc;
    START = 1'b0;
    e.done_cyc = c0 + ((count == 0) ? 1 : count + 18) - 1;
    exp_q.push_back(e);
    BASE_ADDR = 8'($urandom);
    COUNT     = 8'($urandom);
    if (pulse2) begin
      @(posedge CLK);
      #1 START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || BUSY) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("run_completes_in_budget", int'(n < budget), 1);
  endtask

  task automatic run(input int base, input int count, input bit pulse2);
    int c0;
    kick(base, count, pulse2, c0);
    wait_idle(count + 40);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_max"}, int'(MAX), 0);
    chk({tag, "_min"}, int'(MIN), 0);
    chk({tag, "_quotient"}, int'(QUOTIENT), 0);
    chk({tag, "_remainder"}, int'(REMAINDER), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_err"}, int'(ERR), 0);
    chk({tag, "_mem_rd"}, int'(MEM_RD), 0);
    chk({tag, "_mem_addr"}, int'(MEM_ADDR), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, cnt, b;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    RESET = 1'b1;
    @(negedge CLK);
    chk("idle_busy_after_reset", int'(BUSY), 0);

    mem[8'h10] = 8'd10; mem[8'h11] = 8'd200; mem[8'h12] = 8'd3; mem[8'h13] = 8'd50;
    run(8'h10, 4, 1'b0);

    mem[8'h40] = 8'h7F;
    run(8'h40, 1, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run(8'h80, 255, 1'b0);

    run(8'h33, 0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    run(8'h05, 5, 1'b0);

    mem[8'hFE] = 8'd5; mem[8'hFF] = 8'd9; mem[8'h00] = 8'd1;
    run(8'hFE, 3, 1'b1);

    // Abort a run during the divide and make sure nothing is published.
    run(8'h20, 6, 1'b0);
    kick(8'h30, 8, 1'b0, c0);
    while (cyc < c0 + 8 + 6) @(negedge CLK);
    #2 RESET = 1'b0;
    #1 chk_all_zero("abort");
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (25) @(negedge CLK);
    chk("abort_stays_idle", int'(BUSY), 0);
    run(8'h30, 8, 1'b0);

    for (int k = 0; k < 12; k++) begin
      cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 255);
      b   = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(k * 17);
      end else begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      end
      run(b, cnt, 1'b0);
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size() + addr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
